mem_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one 32-bit memory port among four requesters (e.g. fetch, load/store, debug, DMA). It picks a requester, drives the 4:1 select for the shared address/write-data path, holds the grant until the memory acknowledges, then returns read data and a completion pulse to the winner. It sits between the core-side request sources and the single-ported memory/bus interface.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/MUX_4to1_32bit.sv | 23 ++
 rtl/rr_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-way memory port arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/MUX_4to1_32bit.sv
// Generic 4:1 selector for a 32-bit datapath.
module MUX_4to1_32bit (
  input  logic [31:0] IN0,
  input  logic [31:0] IN1,
  input  logic [31:0] IN2,
  input  logic [31:0] IN3,
  input  logic [1:0]  CONTROL,
  output logic [31:0] OUT
);

  // Route the selected input to the output.
  always_comb begin
    OUT = IN0;
    case (CONTROL)
      2'd0:    OUT = IN0;
      2'd1:    OUT = IN1;
      2'd2:    OUT = IN2;
      2'd3:    OUT = IN3;
      default: OUT = IN0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner search: starts just after the last served index and wraps.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   win,
  output logic               any_valid
);

  // First requesting index in rotated order; the last-served index is tried last.
  always_comb begin
    win       = last;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_valid && req[last + SEL_W'(k)]) begin
        win       = last + SEL_W'(k);
        any_valid = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among four requesters: round-robin grant, latch the
// winner's request, hold until MEM_READY, then return RDATA with a DONE pulse.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] ADDR_IN,
  input  logic [NUM_REQ*DATA_W-1:0] WDATA_IN,
  input  logic [NUM_REQ-1:0]        WE_IN,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [1:0]                SEL,
  output logic [NUM_REQ-1:0]        DONE,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      MEM_VALID,
  output logic [DATA_W-1:0]         MEM_ADDR,
  output logic [DATA_W-1:0]         MEM_WDATA,
  output logic                      MEM_WE,
  input  logic                      MEM_READY,
  input  logic [DATA_W-1:0]         MEM_RDATA
);

  import mem_arb_pkg::*;

  arb_state_e       state_r;
  logic [SEL_W-1:0] last_r;
  logic [SEL_W-1:0] win_s;
  logic             any_s;
  logic [31:0]      addr_sel_s;
  logic [31:0]      wdata_sel_s;

  rr_pick u_pick (
    .req       (REQ),
    .last      (last_r),
    .win       (win_s),
    .any_valid (any_s)
  );

  // The muxes follow the pending winner so the latches capture it at the grant edge.
  MUX_4to1_32bit u_addr_mux (
    .IN0     (ADDR_IN[0*DATA_W +: DATA_W]),
    .IN1     (ADDR_IN[1*DATA_W +: DATA_W]),
    .IN2     (ADDR_IN[2*DATA_W +: DATA_W]),
    .IN3     (ADDR_IN[3*DATA_W +: DATA_W]),
    .CONTROL (win_s),
    .OUT     (addr_sel_s)
  );

  MUX_4to1_32bit u_wdata_mux (
    .IN0     (WDATA_IN[0*DATA_W +: DATA_W]),
    .IN1     (WDATA_IN[1*DATA_W +: DATA_W]),
    .IN2     (WDATA_IN[2*DATA_W +: DATA_W]),
    .IN3     (WDATA_IN[3*DATA_W +: DATA_W]),
    .CONTROL (win_s),
    .OUT     (wdata_sel_s)
  );

  // Arbitration/sequencing FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      last_r    <= LAST_RST;
      GNT       <= 4'b0000;
      SEL       <= 2'd0;
      DONE      <= 4'b0000;
      RDATA     <= 32'h0000_0000;
      MEM_VALID <= 1'b0;
      MEM_ADDR  <= 32'h0000_0000;
      MEM_WDATA <= 32'h0000_0000;
      MEM_WE    <= 1'b0;
    end else begin
      DONE <= 4'b0000;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            SEL       <= win_s;
            GNT       <= idx_to_onehot(win_s);
            MEM_ADDR  <= addr_sel_s;
            MEM_WDATA <= wdata_sel_s;
            MEM_WE    <= WE_IN[win_s];
            MEM_VALID <= 1'b1;
            state_r   <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (MEM_READY) begin
            RDATA     <= MEM_RDATA;
            DONE      <= GNT;
            last_r    <= SEL;
            GNT       <= 4'b0000;
            MEM_VALID <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          GNT       <= 4'b0000;
          MEM_VALID <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_mem_port_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   REQ;
  logic [127:0] ADDR_IN;
  logic [127:0] WDATA_IN;
  logic [3:0]   WE_IN;
  logic [3:0]   GNT;
  logic [1:0]   SEL;
  logic [3:0]   DONE;
  logic [31:0]  RDATA;
  logic         MEM_VALID;
  logic [31:0]  MEM_ADDR;
  logic [31:0]  MEM_WDATA;
  logic         MEM_WE;
  logic         MEM_READY;
  logic [31:0]  MEM_RDATA;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR_IN(ADDR_IN), .WDATA_IN(WDATA_IN),
    .WE_IN(WE_IN), .GNT(GNT), .SEL(SEL), .DONE(DONE), .RDATA(RDATA),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WE(MEM_WE), .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding transaction, served round-robin.
  bit          m_live = 0;
  bit          m_busy;
  int          m_last, m_sel;
  logic [3:0]  m_gnt, m_done;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic        m_we;
  bit          m_rd_known, m_out_known;

  always @(posedge CLK) begin
    if (RST) begin
      m_live = 1; m_busy = 0; m_last = 3; m_sel = 0;
      m_gnt = 4'd0; m_done = 4'd0; m_rdata = 32'd0; m_addr = 32'd0;
      m_wdata = 32'd0; m_we = 1'b0; m_rd_known = 1; m_out_known = 1;
    end else if (m_live) begin
      m_done = 4'd0;
      if (!m_busy) begin
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (m_last + k) % 4;
          if (!m_busy && REQ[idx]) begin
            m_busy = 1; m_sel = idx; m_gnt = 4'd1 << idx;
            m_addr = ADDR_IN[32*idx +: 32]; m_wdata = WDATA_IN[32*idx +: 32];
            m_we = WE_IN[idx]; m_out_known = 1;
          end
        end
      end else if (MEM_READY) begin
        m_done = m_gnt; m_last = m_sel; m_gnt = 4'd0; m_busy = 0; m_out_known = 0;
        if (m_we) m_rd_known = 0;
        else begin m_rdata = MEM_RDATA; m_rd_known = 1; end
      end
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge CLK) begin
    if (m_live) begin
      check("gnt", {28'd0, GNT}, {28'd0, m_gnt});
      check("done", {28'd0, DONE}, {28'd0, m_done});
      check("mem_valid", {31'd0, MEM_VALID}, {31'd0, m_busy});
      if (m_rd_known) check("rdata", RDATA, m_rdata);
      if (m_out_known) begin
        check("sel", {30'd0, SEL}, m_sel);
        check("mem_addr", MEM_ADDR, m_addr);
        check("mem_wdata", MEM_WDATA, m_wdata);
        check("mem_we", {31'd0, MEM_WE}, {31'd0, m_we});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; REQ = 4'd0; WE_IN = 4'd0; MEM_READY = 1'b0; MEM_RDATA = 32'd0;
    for (int i = 0; i < 4; i++) begin
      ADDR_IN[32*i +: 32]  = 32'h100 * (i + 1);
      WDATA_IN[32*i +: 32] = 32'hA000_0000 + i;
    end
    step(); step();
    check("rst_gnt", {28'd0, GNT}, 32'd0);
    check("rst_sel", {30'd0, SEL}, 32'd0);
    check("rst_done", {28'd0, DONE}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_valid", {31'd0, MEM_VALID}, 32'd0);
    check("rst_addr", MEM_ADDR, 32'd0);
    check("rst_wdata", MEM_WDATA, 32'd0);
    check("rst_we", {31'd0, MEM_WE}, 32'd0);
    RST = 1'b0;

    // Single read from requester 0
    REQ = 4'b0001; MEM_READY = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
    step();
    check("t1_gnt", {28'd0, GNT}, 32'h1);
    check("t1_addr", MEM_ADDR, 32'h100);
    check("t1_valid", {31'd0, MEM_VALID}, 32'd1);
    step();
    check("t1_done", {28'd0, DONE}, 32'h1);
    check("t1_rdata", RDATA, 32'hDEAD_BEEF);
    check("t1_valid_low", {31'd0, MEM_VALID}, 32'd0);
    REQ = 4'b0000;

    // All requesting, zero-wait memory, fresh priority
    RST = 1'b1; step(); RST = 1'b0;
    REQ = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      MEM_RDATA = 32'h1111_0000 + i;
      step();
      if (i % 2 == 0) begin
        check("rr_gnt", {28'd0, GNT}, 32'd1 << ((i / 2) % 4));
        check("rr_addr", MEM_ADDR, 32'h100 * (((i / 2) % 4) + 1));
        check("rr_nodone", {28'd0, DONE}, 32'd0);
      end else begin
        check("rr_done", {28'd0, DONE}, 32'd1 << ((i / 2) % 4));
        check("rr_idle", {28'd0, GNT}, 32'd0);
      end
    end
    REQ = 4'b0000;

    // Serve 1, then 0 and 1 together: 0 wins
    REQ = 4'b0010; step(); step();
    check("lp_done1", {28'd0, DONE}, 32'h2);
    REQ = 4'b0011; step();
    check("lp_gnt0", {28'd0, GNT}, 32'h1);
    check("lp_sel0", {30'd0, SEL}, 32'd0);
    step();
    REQ = 4'b0000;

    // Stalled write from 2 with inputs changing under it
    REQ = 4'b0100; WE_IN = 4'b0100; WDATA_IN[64 +: 32] = 32'hCAFE_0002;
    MEM_READY = 1'b0; MEM_RDATA = 32'h5555_AAAA;
    step();
    ADDR_IN[64 +: 32] = 32'h999; WDATA_IN[64 +: 32] = 32'h0; WE_IN = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wr_addr", MEM_ADDR, 32'h300);
      check("wr_wdata", MEM_WDATA, 32'hCAFE_0002);
      check("wr_we", {31'd0, MEM_WE}, 32'd1);
      check("wr_nodone", {28'd0, DONE}, 32'd0);
    end
    MEM_READY = 1'b1; step();
    check("wr_done", {28'd0, DONE}, 32'h4);
    REQ = 4'b0000; ADDR_IN[64 +: 32] = 32'h300; WDATA_IN[64 +: 32] = 32'hA000_0002;

    // Reset while busy
    REQ = 4'b0001; MEM_READY = 1'b0; step();
    check("ab_busy", {31'd0, MEM_VALID}, 32'd1);
    RST = 1'b1; REQ = 4'b0000; step();
    check("ab_gnt", {28'd0, GNT}, 32'd0);
    check("ab_done", {28'd0, DONE}, 32'd0);
    check("ab_valid", {31'd0, MEM_VALID}, 32'd0);
    check("ab_addr", MEM_ADDR, 32'd0);
    RST = 1'b0; REQ = 4'b1001; MEM_READY = 1'b1; MEM_RDATA = 32'h0BAD_F00D; step();
    check("ab_last3", {28'd0, GNT}, 32'h1);
    step();
    REQ = 4'b1000; step();
    check("ab_gnt3", {28'd0, GNT}, 32'h8);
    check("ab_sel3", {30'd0, SEL}, 32'd3);
    step();
    check("ab_done3", {28'd0, DONE}, 32'h8);
    REQ = 4'b0000;

    // Request withdrawn right after the grant
    REQ = 4'b0010; MEM_READY = 1'b0; step();
    check("dr_gnt", {28'd0, GNT}, 32'h2);
    REQ = 4'b0000; step(); step();
    check("dr_hold", {28'd0, GNT}, 32'h2);
    MEM_READY = 1'b1; step();
    check("dr_done", {28'd0, DONE}, 32'h2);
    step();
    check("dr_once", {28'd0, DONE}, 32'd0);
    check("dr_idle", {28'd0, GNT}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
